// File: rtl/game_tick_sched_pkg.sv
// Shared definitions for the game tick scheduler: default sizing, channel
// names and the arbiter state encoding.
package game_tick_sched_pkg;

  localparam int NCH_DEF            = 4;
  localparam int PW_DEF             = 16;
  localparam int PRESCALE_DEF       = 1000;
  localparam int DEFAULT_PERIOD_DEF = 333;

  localparam int CH_ASTEROID = 0;
  localparam int CH_BULLET   = 1;
  localparam int CH_SHIP     = 2;
  localparam int CH_SOUND    = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/game_tick_sched_arbiter.sv
// Combinational round-robin pick: the first pending channel strictly after
// rr_ptr, wrapping, reported as one-hot, index and a valid flag.
module tick_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  rr_ptr,
  output logic [NCH-1:0] onehot,
  output logic [IW-1:0]  idx,
  output logic           valid
);

  int k;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int off = NCH; off >= 1; off--) begin
      k = (int'(rr_ptr) + off) % NCH;
      if (pending[IW'(k)]) begin
        onehot          = '0;
        onehot[IW'(k)]  = 1'b1;
        idx             = IW'(k);
        valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_tick_sched.sv
// Base-tick prescaler, per-subsystem period timers and a grant/ack arbiter
// that serialises access to shared game state on the single system clock.
module game_tick_sched
  import game_tick_sched_pkg::*;
#(
  parameter int NCH            = NCH_DEF,
  parameter int PRESCALE       = PRESCALE_DEF,
  parameter int PW             = PW_DEF,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  localparam int IW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_20MHz,
  input  logic           reset,
  input  logic           pause,
  input  logic           cfg_we,
  input  logic [IW-1:0]  cfg_sel,
  input  logic [PW-1:0]  cfg_period,
  input  logic [NCH-1:0] ack,
  output logic           tick_20k,
  output logic [NCH-1:0] grant,
  output logic           busy,
  output logic [NCH-1:0] overrun
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0]  pre_cnt;
  logic [PW-1:0]  period [NCH];
  logic [PW-1:0]  ch_cnt [NCH];
  logic [NCH-1:0] pending;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] pend_n;
  logic [NCH-1:0] ovr_n;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  gnt_idx;
  arb_state_t     state;
  logic           cfg_hit;

  logic [NCH-1:0] pick_onehot;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;

  assign cfg_hit = cfg_we && (int'(cfg_sel) < NCH);

  tick_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    expire = '0;
    for (int i = 0; i < NCH; i++) begin
      if (tick_20k && (period[i] != '0) && (ch_cnt[i] == period[i] - PW'(1)))
        expire[i] = 1'b1;
    end
  end

  // Grant consumes the old request first; a same-cycle expiry then re-arms it,
  // and a config write to the channel overrides both.
  always_comb begin
    pend_n = pending;
    ovr_n  = overrun;
    if (state == ST_IDLE && pick_valid)
      pend_n[pick_idx] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (expire[i]) begin
        if (pending[i])
          ovr_n[i] = 1'b1;
        pend_n[i] = 1'b1;
      end
    end
    if (cfg_hit) begin
      pend_n[cfg_sel] = 1'b0;
      ovr_n[cfg_sel]  = 1'b0;
    end
  end

  always_ff @(posedge clk_20MHz) begin
    if (reset) begin
      pre_cnt  <= '0;
      tick_20k <= 1'b0;
    end else if (pause) begin
      tick_20k <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt  <= '0;
      tick_20k <= 1'b1;
    end else begin
      pre_cnt  <= pre_cnt + CW'(1);
      tick_20k <= 1'b0;
    end
  end

  always_ff @(posedge clk_20MHz) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        period[i] <= PW'(DEFAULT_PERIOD);
        ch_cnt[i] <= '0;
      end
      pending <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit && cfg_sel == IW'(i)) begin
          period[i] <= cfg_period;
          ch_cnt[i] <= '0;
        end else if (tick_20k && period[i] != '0) begin
          ch_cnt[i] <= expire[i] ? '0 : ch_cnt[i] + PW'(1);
        end
      end
      pending <= pend_n;
      overrun <= ovr_n;
    end
  end

  always_ff @(posedge clk_20MHz) begin
    if (reset) begin
      state   <= ST_IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      rr_ptr  <= IW'(NCH - 1);
      gnt_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant   <= pick_onehot;
            gnt_idx <= pick_idx;
            busy    <= 1'b1;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (ack[gnt_idx]) begin
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= gnt_idx;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed and randomized bench for game_tick_sched, compared every cycle
// against a tick-count based reference model.
module tb_game_tick_sched;

  localparam int NCH      = 4;
  localparam int PRESCALE = 10;
  localparam int PW       = 16;
  localparam int DEFP     = 7;

  logic           clk_20MHz = 1'b0;
  logic           reset = 1'b1;
  logic           pause = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_sel = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic [NCH-1:0] ack = '0;
  logic           tick_20k;
  logic [NCH-1:0] grant;
  logic           busy;
  logic [NCH-1:0] overrun;

  game_tick_sched #(.NCH(NCH), .PRESCALE(PRESCALE), .PW(PW), .DEFAULT_PERIOD(DEFP)) dut (
    .clk_20MHz  (clk_20MHz),
    .reset      (reset),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_period (cfg_period),
    .ack        (ack),
    .tick_20k   (tick_20k),
    .grant      (grant),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #25 clk_20MHz = ~clk_20MHz;

  int checks = 0;
  int errors = 0;

  // Reference model: unpaused-cycle count, ticks seen since last config.
  int             m_cycles;
  bit             m_tick;
  int             m_per [NCH];
  int             m_ticks [NCH];
  logic [NCH-1:0] m_pend, m_ovr, m_grant;
  bit             m_busy;
  int             m_last, m_gch;

  int             cyc, first_tick, first_grant, ack_dly, held, rises, tick_cnt;
  logic [NCH-1:0] prev_grant;
  logic [NCH-1:0] gq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cycles = 0; m_tick = 0; m_pend = '0; m_ovr = '0; m_grant = '0;
    m_busy = 0; m_last = NCH - 1; m_gch = -1;
    for (int i = 0; i < NCH; i++) begin m_per[i] = DEFP; m_ticks[i] = 0; end
  endtask

  task automatic model_update(input bit rst, input bit pz, input bit we,
                              input logic [1:0] sel, input logic [PW-1:0] per);
    bit             old_tick;
    logic [NCH-1:0] old_pend, expv;
    int             k;
    if (rst) begin model_reset(); return; end
    old_tick = m_tick;
    old_pend = m_pend;
    expv     = '0;
    if (pz) m_tick = 0;
    else begin m_cycles++; m_tick = (m_cycles % PRESCALE) == 0; end
    for (int i = 0; i < NCH; i++) begin
      if (old_tick && m_per[i] != 0) begin
        if ((m_ticks[i] + 1) % m_per[i] == 0) expv[i] = 1'b1;
        m_ticks[i]++;
      end
    end
    if (m_gch < 0) begin
      k = -1;
      for (int off = 1; off <= NCH; off++)
        if (k < 0 && old_pend[(m_last + off) % NCH]) k = (m_last + off) % NCH;
      if (k >= 0) begin
        m_gch = k; m_grant = '0; m_grant[k] = 1'b1; m_busy = 1; m_pend[k] = 1'b0;
      end
    end else if (ack[m_gch]) begin
      m_grant = '0; m_busy = 0; m_last = m_gch; m_gch = -1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (expv[i]) begin
        if (old_pend[i]) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (we && int'(sel) < NCH) begin
      m_per[sel] = int'(per); m_ticks[sel] = 0; m_pend[sel] = 1'b0; m_ovr[sel] = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input bit pz, input bit we,
                      input logic [1:0] sel, input logic [PW-1:0] per);
    reset = rst; pause = pz; cfg_we = we; cfg_sel = sel; cfg_period = per;
    if (ack_dly < 0) ack = NCH'($urandom);
    else if (ack_dly > 0 && held >= ack_dly) ack = m_grant;
    else ack = '0;
    @(posedge clk_20MHz);
    model_update(rst, pz, we, sel, per);
    #1;
    check("tick_20k", 32'(tick_20k), 32'(m_tick));
    check("grant",    32'(grant),    32'(m_grant));
    check("busy",     32'(busy),     32'(m_busy));
    check("overrun",  32'(overrun),  32'(m_ovr));
    if (rst) begin cyc = 0; first_tick = -1; first_grant = -1; end
    else cyc++;
    if (!rst && tick_20k) begin
      tick_cnt++;
      if (first_tick < 0) first_tick = cyc;
    end
    if (grant != '0 && prev_grant == '0) begin
      rises++; gq.push_back(grant);
      if (first_grant < 0) first_grant = cyc;
    end
    prev_grant = grant;
    if (m_grant != '0) held++; else held = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 2'd0, '0);
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [PW-1:0] per);
    step(0, 0, 1, sel, per);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 2'd0, '0);
    step(1, 0, 0, 2'd0, '0);
    rises = 0; tick_cnt = 0; gq.delete();
  endtask

  initial begin
    bit found;
    bit pz;
    ack_dly = 0; held = 0; rises = 0; tick_cnt = 0; prev_grant = '0;
    cyc = 0; first_tick = -1; first_grant = -1;
    model_reset();

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_tick", 32'(tick_20k), 32'h0);

    // Only the asteroid channel, period 3, ack two cycles after grant
    ack_dly = 2;
    cfg(2'd1, 0); cfg(2'd2, 0); cfg(2'd3, 0); cfg(2'd0, 3);
    idle(36 - cyc);
    check("s1_first_tick", first_tick, 10);
    check("s1_first_grant", first_grant, 32);
    check("s1_rises", rises, 1);
    check("s1_grant_val", (gq.size() > 0) ? 32'(gq[0]) : 32'hx, 32'h1);

    // All channels period 1, quick ack: strict rotation
    do_reset();
    ack_dly = 1;
    cfg(2'd0, 1); cfg(2'd1, 1); cfg(2'd2, 1); cfg(2'd3, 1);
    idle(60);
    check("s2_rotation", (gq.size() >= 4) ? {16'h0, gq[0], gq[1], gq[2], gq[3]} : 32'hx, 32'h1248);
    check("s2_overrun", 32'(overrun), 32'h0);

    // Bullet channel never acked: pending then sticky overrun
    do_reset();
    ack_dly = 0;
    cfg(2'd0, 0); cfg(2'd2, 0); cfg(2'd3, 0); cfg(2'd1, 1);
    idle(60 - cyc);
    check("s3_grant_held", 32'(grant), 32'h2);
    check("s3_overrun", 32'(overrun), 32'h2);
    cfg(2'd1, 0);
    check("s3_cfg_clr_ovr", 32'(overrun), 32'h0);
    check("s3_grant_kept", 32'(grant), 32'h2);
    idle(30);
    ack_dly = 1;
    idle(20);
    check("s3_no_regrant", rises, 1);
    check("s3_busy_low", 32'(busy), 32'h0);

    // Pause mid-count while pending requests are still served
    do_reset();
    ack_dly = 0;
    cfg(2'd0, 1); cfg(2'd1, 1); cfg(2'd2, 1); cfg(2'd3, 1);
    idle(15 - cyc);
    rises = 0; tick_cnt = 0; ack_dly = 1;
    repeat (25) step(0, 1, 0, 2'd0, '0);
    check("s4_pause_ticks", tick_cnt, 0);
    check("s4_pause_grants", rises, 3);
    first_tick = -1;
    idle(10);
    check("s4_resume_tick", first_tick, 45);

    // Config write colliding with an expiry of the same channel
    do_reset();
    ack_dly = 1;
    cfg(2'd0, 0); cfg(2'd1, 0); cfg(2'd3, 0); cfg(2'd2, 2);
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_tick && ((m_ticks[2] + 1) % m_per[2] == 0)) found = 1;
      else idle(1);
    end
    check("s5_found_expiry", 32'(found), 32'h1);
    cfg(2'd2, 4);
    idle(5);
    check("s5_no_pending", rises, 0);
    idle(70 - cyc);
    check("s5_new_period", first_grant, 62);

    // Reset while the ship channel holds the grant
    do_reset();
    ack_dly = 0;
    cfg(2'd0, 0); cfg(2'd1, 0); cfg(2'd3, 0); cfg(2'd2, 1);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      idle(1);
      if (grant == 4'b0100) found = 1;
    end
    check("s6_found_grant", 32'(found), 32'h1);
    idle(30);
    check("s6_ovr_before", 32'(overrun), 32'h4);
    step(1, 0, 0, 2'd0, '0);
    check("s6_rst_grant", 32'(grant), 32'h0);
    check("s6_rst_busy", 32'(busy), 32'h0);
    check("s6_rst_overrun", 32'(overrun), 32'h0);
    rises = 0; gq.delete(); ack_dly = 1;
    idle(80);
    check("s6_default_period", first_grant, 72);
    check("s6_default_ch", (gq.size() > 0) ? 32'(gq[0]) : 32'hx, 32'h1);

    // Randomized traffic
    do_reset();
    ack_dly = -1;
    pz = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19) == 0) pz = ~pz;
      step(($urandom_range(599) == 0), pz, ($urandom_range(11) == 0),
           2'($urandom), PW'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
